// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-address generator: BTB counter encodings,
// the conditional-branch opcode and BTB geometry helpers.
package pc_pkg;

    // 2-bit saturating direction counter states
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam logic [6:0] BRANCH_OP = 7'b1100011;

    // Width of the BTB index field (pc[log2(depth)+1:2])
    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Width of the BTB tag field (pc[xlen-1:log2(depth)+2])
    function automatic int unsigned tag_width(input int unsigned xlen, input int unsigned depth);
        return xlen - $clog2(depth) - 2;
    endfunction

    // Saturating step of a direction counter toward taken (up=1) or not-taken
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        logic [1:0] r;
        r = c;
        if (up) begin
            if (c != ST) r = c + 2'd1;
        end else begin
            if (c != SNT) r = c - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer storage: two combinational read ports
// (fetch lookup and training lookup), one synchronous write port, async clear.
module btb_table
    import pc_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [idx_width(DEPTH)-1:0]         lk_idx,
    output logic                                lk_valid,
    output logic [tag_width(XLEN, DEPTH)-1:0]   lk_tag,
    output logic [XLEN-1:0]                     lk_target,
    output logic [1:0]                          lk_ctr,
    input  logic [idx_width(DEPTH)-1:0]         tr_idx,
    output logic                                tr_valid,
    output logic [tag_width(XLEN, DEPTH)-1:0]   tr_tag,
    output logic [XLEN-1:0]                     tr_target,
    output logic [1:0]                          tr_ctr,
    input  logic                                wr_en,
    input  logic [idx_width(DEPTH)-1:0]         wr_idx,
    input  logic [tag_width(XLEN, DEPTH)-1:0]   wr_tag,
    input  logic [XLEN-1:0]                     wr_target,
    input  logic [1:0]                          wr_ctr
);

    localparam int unsigned TW = tag_width(XLEN, DEPTH);

    logic [DEPTH-1:0] valid_q;
    logic [TW-1:0]    tag_q    [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];

    // Entry storage; reset invalidates everything and parks counters at WNT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (wr_en) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
            ctr_q[wr_idx]    <= wr_ctr;
        end
    end

    assign lk_valid  = valid_q[lk_idx];
    assign lk_tag    = tag_q[lk_idx];
    assign lk_target = target_q[lk_idx];
    assign lk_ctr    = ctr_q[lk_idx];

    assign tr_valid  = valid_q[tr_idx];
    assign tr_tag    = tag_q[tr_idx];
    assign tr_target = target_q[tr_idx];
    assign tr_ctr    = ctr_q[tr_idx];

endmodule

// File: rtl/pc_predictor_unit.sv
// Fetch-address generator: PC register, BTB-based next-PC prediction,
// mispredict redirect and BTB training.
// Optional macro PC_PERF_CNT_EN adds perf_branches / perf_mispredicts counters.
module pc_predictor_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 64,
    parameter int unsigned     BTB_DEPTH    = 16,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INSTR_BYTES  = 4
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pred_next_pc,
    input  logic            resolve_valid,
    input  logic [XLEN-1:0] resolve_pc,
    input  logic            resolve_is_cond,
    input  logic            resolve_is_jump,
    input  logic            resolve_taken,
    input  logic [XLEN-1:0] resolve_next_pc,
    input  logic [XLEN-1:0] resolve_pred_next_pc,
    output logic            flush
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam int unsigned IW = idx_width(BTB_DEPTH);
    localparam int unsigned TW = tag_width(XLEN, BTB_DEPTH);

    logic            lk_valid;
    logic [TW-1:0]   lk_tag;
    logic [XLEN-1:0] lk_target;
    logic [1:0]      lk_ctr;
    logic            tr_valid;
    logic [TW-1:0]   tr_tag;
    logic [XLEN-1:0] tr_target;
    logic [1:0]      tr_ctr;
    logic            wr_en;
    logic [XLEN-1:0] wr_target;
    logic [1:0]      wr_ctr;
    logic            hit;
    logic            tr_hit;
    logic            mispredict;
    logic            train_evt;
    logic [XLEN-1:0] pc_next;
    logic [1:0]      unused_bits;

    btb_table #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk       (CLK),
        .rst       (RST),
        .lk_idx    (pc[IW+1:2]),
        .lk_valid  (lk_valid),
        .lk_tag    (lk_tag),
        .lk_target (lk_target),
        .lk_ctr    (lk_ctr),
        .tr_idx    (resolve_pc[IW+1:2]),
        .tr_valid  (tr_valid),
        .tr_tag    (tr_tag),
        .tr_target (tr_target),
        .tr_ctr    (tr_ctr),
        .wr_en     (wr_en),
        .wr_idx    (resolve_pc[IW+1:2]),
        .wr_tag    (resolve_pc[XLEN-1:IW+2]),
        .wr_target (wr_target),
        .wr_ctr    (wr_ctr)
    );

    // Instruction alignment bits never participate in BTB addressing
    assign unused_bits = resolve_pc[1:0];

    // Zero-latency prediction from the current PC
    assign hit          = lk_valid && (lk_tag == pc[XLEN-1:IW+2]);
    assign pred_next_pc = (hit && lk_ctr[1]) ? lk_target : pc + XLEN'(INSTR_BYTES);

    assign mispredict = resolve_valid && (resolve_next_pc != resolve_pred_next_pc);
    assign flush      = mispredict;

    assign train_evt = resolve_valid && (resolve_is_cond || resolve_is_jump);
    assign tr_hit    = tr_valid && (tr_tag == resolve_pc[XLEN-1:IW+2]);

    // Training update: counter/target refresh on hit, allocation on taken miss
    always_comb begin
        wr_en     = 1'b0;
        wr_ctr    = tr_ctr;
        wr_target = tr_target;
        if (train_evt) begin
            if (tr_hit) begin
                wr_en = 1'b1;
                if (resolve_is_jump) begin
                    wr_ctr    = ST;
                    wr_target = resolve_next_pc;
                end else begin
                    wr_ctr = ctr_step(tr_ctr, resolve_taken);
                    if (resolve_taken) wr_target = resolve_next_pc;
                end
            end else if (resolve_taken) begin
                wr_en     = 1'b1;
                wr_target = resolve_next_pc;
                wr_ctr    = resolve_is_jump ? ST : WT;
            end
        end
    end

    // Next-PC priority: redirect beats the handshake, otherwise hold
    always_comb begin
        pc_next = pc;
        if (mispredict) begin
            pc_next = resolve_next_pc;
        end else if (fetch_valid && fetch_ready && !stall) begin
            pc_next = pred_next_pc;
        end
    end

    // PC register and fetch-valid flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc          <= RESET_VECTOR;
            fetch_valid <= 1'b0;
        end else begin
            pc          <= pc_next;
            fetch_valid <= 1'b1;
        end
    end

`ifdef PC_PERF_CNT_EN
    // Wrapping event counters for training events and mispredict cycles
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (train_evt)  perf_branches    <= perf_branches + 32'd1;
            if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_predictor_unit.sv
// Bench for pc_predictor_unit: directed vector table plus randomized traffic
// checked against a behavioural BTB/PC model.
`timescale 1ns/1ps
module tb_pc_predictor_unit;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned IW    = 4;
    localparam logic [63:0] RV    = 64'h1000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        fetch_valid;
    logic        fetch_ready = 1'b0;
    logic        stall = 1'b0;
    logic [63:0] pc;
    logic [63:0] pred_next_pc;
    logic        resolve_valid = 1'b0;
    logic [63:0] resolve_pc = '0;
    logic        resolve_is_cond = 1'b0;
    logic        resolve_is_jump = 1'b0;
    logic        resolve_taken = 1'b0;
    logic [63:0] resolve_next_pc = '0;
    logic [63:0] resolve_pred_next_pc = '0;
    logic        flush;
`ifdef PC_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    pc_predictor_unit #(
        .XLEN         (XLEN),
        .BTB_DEPTH    (DEPTH),
        .RESET_VECTOR (RV),
        .INSTR_BYTES  (4)
    ) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .fetch_valid          (fetch_valid),
        .fetch_ready          (fetch_ready),
        .stall                (stall),
        .pc                   (pc),
        .pred_next_pc         (pred_next_pc),
        .resolve_valid        (resolve_valid),
        .resolve_pc           (resolve_pc),
        .resolve_is_cond      (resolve_is_cond),
        .resolve_is_jump      (resolve_is_jump),
        .resolve_taken        (resolve_taken),
        .resolve_next_pc      (resolve_next_pc),
        .resolve_pred_next_pc (resolve_pred_next_pc),
        .flush                (flush)
`ifdef PC_PERF_CNT_EN
        ,
        .perf_branches        (perf_branches),
        .perf_mispredicts     (perf_mispredicts)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [63:0] m_pc;
    bit          m_fv;
    bit          m_valid [DEPTH];
    logic [63:0] m_tag   [DEPTH];
    logic [63:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    int unsigned m_br;
    int unsigned m_mp;

    typedef struct {
        bit          rst;
        bit          ready;
        bit          stl;
        bit          rv;
        logic [63:0] rpc;
        bit          cond;
        bit          jump;
        bit          taken;
        logic [63:0] rnext;
        logic [63:0] rpred;
        logic [63:0] e_pc;
        logic [63:0] e_pred;
        bit          e_flush;
        bit          e_fv;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_pc = RV;
        m_fv = 1'b0;
        m_br = 0;
        m_mp = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
    endfunction

    function automatic logic [63:0] m_pred();
        int i;
        i = int'((m_pc >> 2) % DEPTH);
        if (m_valid[i] && (m_tag[i] == (m_pc >> (IW + 2))) && m_ctr[i] >= 2) return m_tgt[i];
        return m_pc + 64'd4;
    endfunction

    function automatic void m_edge();
        logic [63:0] np;
        bit          mp;
        int          i;
        bit          h;
        np = m_pred();
        mp = resolve_valid && (resolve_next_pc != resolve_pred_next_pc);
        if (resolve_valid && (resolve_is_cond || resolve_is_jump)) begin
            i = int'((resolve_pc >> 2) % DEPTH);
            h = m_valid[i] && (m_tag[i] == (resolve_pc >> (IW + 2)));
            m_br++;
            if (h) begin
                if (resolve_is_jump) begin
                    m_ctr[i] = 3;
                    m_tgt[i] = resolve_next_pc;
                end else if (resolve_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = resolve_next_pc;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (resolve_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = resolve_pc >> (IW + 2);
                m_tgt[i]   = resolve_next_pc;
                m_ctr[i]   = resolve_is_jump ? 3 : 2;
            end
        end
        if (mp) m_mp++;
        if (mp) m_pc = resolve_next_pc;
        else if (m_fv && fetch_ready && !stall) m_pc = np;
        m_fv = 1'b1;
    endfunction

    task automatic check_model();
        chk("pc", pc, m_pc);
        chk("fetch_valid", 64'(fetch_valid), 64'(m_fv));
        chk("pred_next_pc", pred_next_pc, m_pred());
        chk("flush", 64'(flush), 64'(resolve_valid && (resolve_next_pc != resolve_pred_next_pc)));
`ifdef PC_PERF_CNT_EN
        chk("perf_branches", 64'(perf_branches), 64'(m_br));
        chk("perf_mispredicts", 64'(perf_mispredicts), 64'(m_mp));
`endif
    endtask

    task automatic idle_inputs();
        fetch_ready          = 1'b1;
        stall                = 1'b0;
        resolve_valid        = 1'b0;
        resolve_pc           = '0;
        resolve_is_cond      = 1'b0;
        resolve_is_jump      = 1'b0;
        resolve_taken        = 1'b0;
        resolve_next_pc      = '0;
        resolve_pred_next_pc = '0;
    endtask

    // Asynchronous reset pulse starting right after a falling edge
    task automatic pulse_reset();
        idle_inputs();
        RST = 1'b1;
        m_reset();
        #1;
        chk("rst_pc", pc, RV);
        chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
`ifdef PC_PERF_CNT_EN
        chk("rst_perf_branches", 64'(perf_branches), 64'd0);
        chk("rst_perf_mispredicts", 64'(perf_mispredicts), 64'd0);
`endif
        @(posedge CLK);
        #1;
        chk("rst_hold_pc", pc, RV);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic run_row(input vec_t v, input bit use_exp);
        if (v.rst) pulse_reset();
        fetch_ready          = v.ready;
        stall                = v.stl;
        resolve_valid        = v.rv;
        resolve_pc           = v.rpc;
        resolve_is_cond      = v.cond;
        resolve_is_jump      = v.jump;
        resolve_taken        = v.taken;
        resolve_next_pc      = v.rnext;
        resolve_pred_next_pc = v.rpred;
        #1;
        if (use_exp) begin
            chk("tbl_pc", pc, v.e_pc);
            chk("tbl_pred", pred_next_pc, v.e_pred);
            chk("tbl_flush", 64'(flush), 64'(v.e_flush));
            chk("tbl_fetch_valid", 64'(fetch_valid), 64'(v.e_fv));
        end
        check_model();
        @(posedge CLK);
        m_edge();
        @(negedge CLK);
    endtask

    function automatic vec_t mk(input bit rst, input bit ready, input bit stl, input bit rv,
                                input logic [63:0] rpc, input bit cond, input bit jump, input bit taken,
                                input logic [63:0] rnext, input logic [63:0] rpred,
                                input logic [63:0] e_pc, input logic [63:0] e_pred,
                                input bit e_flush, input bit e_fv);
        vec_t v;
        v.rst = rst; v.ready = ready; v.stl = stl; v.rv = rv; v.rpc = rpc;
        v.cond = cond; v.jump = jump; v.taken = taken; v.rnext = rnext; v.rpred = rpred;
        v.e_pc = e_pc; v.e_pred = e_pred; v.e_flush = e_flush; v.e_fv = e_fv;
        return v;
    endfunction

    initial begin
        vec_t v;
        int   typ;
        m_reset();
        idle_inputs();

        //            rst rdy stl rv  rpc       c  j  t  rnext     rpred      e_pc      e_pred   fl fv
        tbl.push_back(mk(1, 1, 0, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h1000, 64'h1004, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h1000, 64'h1004, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h1004, 64'h1008, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h1008, 64'h100c, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h1008, 64'h100c, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h1008, 64'h100c, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h1008, 64'h100c, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h1008, 64'h100c, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h100c, 64'h1010, 0, 1));
        // cond branch at 0x1010 taken -> allocate WT, redirect to 0x2000
        tbl.push_back(mk(0, 1, 0, 1, 64'h1010, 1, 0, 1, 64'h2000, 64'h1014, 64'h1010, 64'h1014, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 64'h0,    0, 0, 0, 64'h1010, 64'h2004, 64'h2000, 64'h2004, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h1010, 64'h2000, 0, 1));
        // two not-taken trainings: WT -> WNT -> SNT
        tbl.push_back(mk(0, 1, 0, 1, 64'h1010, 1, 0, 0, 64'h1014, 64'h2000, 64'h2000, 64'h2004, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 64'h1010, 1, 0, 0, 64'h1014, 64'h1014, 64'h1014, 64'h1018, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 64'h0,    0, 0, 0, 64'h1010, 64'h101c, 64'h1018, 64'h101c, 1, 1));
        // four taken trainings: SNT -> WNT -> WT -> ST -> ST (first one also same-index lookup)
        tbl.push_back(mk(0, 1, 0, 1, 64'h1010, 1, 0, 1, 64'h2000, 64'h2000, 64'h1010, 64'h1014, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 64'h1010, 1, 0, 1, 64'h2000, 64'h2000, 64'h1014, 64'h1018, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 64'h1010, 1, 0, 1, 64'h2000, 64'h2000, 64'h1018, 64'h101c, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 64'h1010, 1, 0, 1, 64'h2000, 64'h2000, 64'h101c, 64'h1020, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 64'h0,    0, 0, 0, 64'h1010, 64'h1024, 64'h1020, 64'h1024, 1, 1));
        // mispredict while stalled still redirects; ST -> WT
        tbl.push_back(mk(0, 1, 1, 1, 64'h1010, 1, 0, 0, 64'h1014, 64'h2000, 64'h1010, 64'h2000, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 64'h0,    0, 0, 0, 64'h1010, 64'h1018, 64'h1014, 64'h1018, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h1010, 64'h2000, 0, 1));
        // mid-run reset clears the BTB; then jump allocation at 0x1020
        tbl.push_back(mk(1, 1, 0, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h1000, 64'h1004, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 64'h0,    0, 0, 0, 64'h1010, 64'h1004, 64'h1000, 64'h1004, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 64'h1020, 0, 1, 1, 64'h3000, 64'h1024, 64'h1010, 64'h1014, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 64'h0,    0, 0, 0, 64'h1020, 64'h3004, 64'h3000, 64'h3004, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    64'h1020, 64'h3000, 0, 1));

        @(negedge CLK);
        foreach (tbl[k]) run_row(tbl[k], 1'b1);

        // Randomized traffic over a small address window to force hits and tag conflicts
        for (int n = 0; n < 3000; n++) begin
            v.rst   = ($urandom_range(0, 199) == 0);
            v.ready = ($urandom_range(0, 9) != 0);
            v.stl   = ($urandom_range(0, 4) == 0);
            v.rv    = ($urandom_range(0, 2) == 0);
            v.rpc   = 64'h1000 + 64'($urandom_range(0, 31)) * 64'd4;
            typ     = int'($urandom_range(0, 2));
            v.cond  = (typ == 0);
            v.jump  = (typ == 1);
            v.taken = v.jump ? 1'b1 : 1'($urandom_range(0, 1));
            v.rnext = 64'h1000 + 64'($urandom_range(0, 63)) * 64'd4;
            v.rpred = ($urandom_range(0, 1) == 1) ? v.rnext
                                                  : 64'h1000 + 64'($urandom_range(0, 63)) * 64'd4;
            v.e_pc = '0; v.e_pred = '0; v.e_flush = 1'b0; v.e_fv = 1'b0;
            run_row(v, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
